// File: rtl/tdc_count_seq.sv
// TDC ripple-counter sequencer: unwraps sampled counts into per-cycle deltas,
// accumulates DCO phase, and runs windowed frequency measurements on request.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_OFF    | idle, tracking disabled
// S_SETTLE | counter warm-up, samples discarded for SETTLE_CYC edges
// S_TRACK  | delta/phase_acc updated every edge, waiting for start
// S_MEAS   | tracking plus summing deltas over the requested window
module tdc_count_seq #(
  parameter int CNT_W      = 7,
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] count,
  input  logic             start,
  input  logic [7:0]       n_cycles,
  output logic             valid,
  output logic [CNT_W-1:0] delta,
  output logic [ACC_W-1:0] phase_acc,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] freq_count
);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_MEAS   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       settle_cnt;
  logic [8:0]       remaining;
  logic [ACC_W-1:0] freq_prev;
  logic [CNT_W-1:0] delta_nxt;
  logic [ACC_W-1:0] delta_ext;

  // Modular subtraction unwraps a single counter wrap per reference cycle.
  assign delta_nxt = count - cnt_q;
  assign delta_ext = {{(ACC_W-CNT_W){1'b0}}, delta_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      cnt_q      <= '0;
      settle_cnt <= '0;
      remaining  <= '0;
      freq_prev  <= '0;
      valid      <= 1'b0;
      delta      <= '0;
      phase_acc  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      freq_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_OFF: begin
          if (en) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            cnt_q      <= count;
          end
        end
        S_SETTLE: begin
          if (!en) begin
            state <= S_OFF;
          end else begin
            cnt_q      <= count;
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) state <= S_TRACK;
          end
        end
        default: begin
          if (!en) begin
            // Abort discards the partial window and keeps the last result.
            state <= S_OFF;
            valid <= 1'b0;
            busy  <= 1'b0;
            if (state == S_MEAS) freq_count <= freq_prev;
          end else begin
            delta     <= delta_nxt;
            cnt_q     <= count;
            valid     <= 1'b1;
            phase_acc <= phase_acc + delta_ext;
            if (state == S_TRACK) begin
              if (start) begin
                state      <= S_MEAS;
                busy       <= 1'b1;
                freq_prev  <= freq_count;
                freq_count <= '0;
                remaining  <= (n_cycles == 8'd0) ? 9'd256 : {1'b0, n_cycles};
              end
            end else begin
              freq_count <= freq_count + delta_ext;
              remaining  <= remaining - 9'd1;
              if (remaining == 9'd1) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_TRACK;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/tdc_count_seq.md
# tdc_count_seq

Sequencer and accumulator for the TDC ripple counter that counts DCO edges. Each reference-clock edge it captures the 7-bit sampled count, unwraps it into a per-cycle increment, and keeps a wide running DCO phase accumulator. It also runs windowed frequency measurements on request: it sums increments over N reference cycles for DCO coarse/fine calibration. It sits between the TDC counter and the ADPLL loop/calibration logic, and owns counter warm-up after enable.

## Interface
- CNT_W, 7: width of the TDC counter value (modulus 2^CNT_W)
- ACC_W, 16: width of phase accumulator and measurement result
- SETTLE_CYC, 3: reference cycles discarded after enable (range 1..15)
- clk  in  1  reference clock (FREF); the TDC counter samples on the same rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  tracking enable (level)
- count  in  CNT_W  sampled ripple-counter value, updated shortly after each clk rising edge
- start  in  1  single-cycle measurement request
- n_cycles  in  8  measurement window length in reference cycles, captured on accepted start
- valid  out  1  delta/phase_acc updated this cycle
- delta  out  CNT_W  DCO edges counted in last reference cycle
- phase_acc  out  ACC_W  running sum of delta, wraps mod 2^ACC_W
- busy  out  1  measurement in progress
- done  out  1  one-cycle pulse: freq_count is final
- freq_count  out  ACC_W  sum of delta over the last completed window

## Operation
- State machine: OFF, SETTLE, TRACK, MEAS. Reset gives OFF and clears all outputs and internal registers to 0.
- OFF: en=1 at an edge → SETTLE. settle_cnt←0, cnt_q←count.
- SETTLE: each edge cnt_q←count and settle_cnt++. Once SETTLE_CYC edges have been spent in SETTLE → TRACK. valid stays 0 and phase_acc is not updated.
- TRACK/MEAS, every edge:
  - delta←(count−cnt_q) mod 2^CNT_W, computed as an unsigned CNT_W-bit subtraction with borrow dropped.
  - cnt_q←count, valid←1.
  - phase_acc←phase_acc+zero-extended delta, mod 2^ACC_W.
- Operating constraint: fewer than 2^CNT_W DCO edges per reference cycle. Aliasing beyond that is not detected.
- TRACK, start=1 → MEAS:
  - busy←1, freq_count←0, remaining←n_cycles.
  - If n_cycles=0, the window is 256 cycles.
- MEAS, every edge:
  - freq_count += delta of this edge; remaining decrements.
  - On the edge where the last of the n_cycles deltas is added: done←1 for one cycle, busy←0, → TRACK.
- start is ignored in OFF, SETTLE and MEAS. No queuing.
- en=0 at any edge in SETTLE/TRACK/MEAS → OFF:
  - valid←0 and busy←0. done is not pulsed.
  - freq_count keeps its last completed value. An aborted partial sum is discarded: freq_count is restored to its value from before the start.
  - phase_acc holds.
- Re-enable re-enters SETTLE. phase_acc continues from its held value, with no jump: cnt_q is reloaded in SETTLE.
- freq_count is saturating-free and wraps mod 2^ACC_W. ACC_W ≥ CNT_W+8 guarantees no wrap.

## Timing
- valid first asserts on the (SETTLE_CYC+1)th edge after the edge that sampled en=1.
- Latency count→delta/phase_acc: one edge. Values are registered on the edge that samples count.
- done asserts on the n_cycles-th edge after the edge that accepted start, i.e. that edge plus n_cycles. busy is 1 from the accept edge through the cycle before done. done and busy=0 are simultaneous.
- start on the same edge done is asserted: the block is still in MEAS for that edge, so start is ignored. The earliest new accept is the next edge.
- en=0 on the same edge as window completion: abort wins, and done is not pulsed.
- rst_n assertion mid-window: immediate clear of all outputs, state OFF.

## Test plan
- Enable with count stepping +37/cycle from 0, SETTLE_CYC=3 → valid from the 4th edge, delta=37 constant, phase_acc increments by 37 per valid cycle.
- Counter wrap, count sequence 91,120,29,66 in TRACK → deltas 29,37,37. phase_acc shows no discontinuity.
- start with n_cycles=10, delta=37 → busy for 10 cycles, done pulse at accept+10, freq_count=370, back to TRACK with valid continuous.
- n_cycles=0 with delta=100 → done at accept+256, freq_count=25600 (ACC_W=16).
- en dropped at window cycle 5 after a prior result of 370 → busy=0, no done, freq_count=370. Re-enable → 3 settle cycles, phase_acc resumes from its held value.
- start pulsed in SETTLE and during MEAS, and rst_n pulsed mid-MEAS → start ignored in each case; reset clears all outputs to 0 asynchronously and the state returns to OFF.
